// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU.
// Owns the shared memory port: instruction fetch, opcode dispatch, LD/ST data
// accesses and retirement. Decoder RegWrite/NZ are gated so the register file
// and flags only update on the commit cycle.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | halted at an instruction boundary, waiting for run
// FETCH  | instruction read at PC; ir_load on mem_rdy
// DECODE | one-cycle dispatch on opcode
// EXEC   | ALU/branch/NOP commit: gated reg/flag write, PC advance, retire
// LOAD   | data read for ld
// WB     | ld commit: register write, PC advance, retire
// STORE  | data write for st; commit in the mem_rdy cycle
// ERR    | memory timeout; sticky until reset
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [4:0]       opcode,
    input  logic             dec_regwrite,
    input  logic             dec_nz,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_load,
    output logic             reg_we,
    output logic             nz_we,
    output logic             pc_enable,
    output logic             bus_err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_LOAD   = 3'b100,
        S_WB     = 3'b101,
        S_STORE  = 3'b110,
        S_ERR    = 3'b111
    } state_t;

    localparam logic [4:0] OP_LD = 5'b00100;
    localparam logic [4:0] OP_ST = 5'b00101;

    state_t     state;
    state_t     state_next;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    logic       mem_state;
    logic       retire;

    // The request has waited its last allowed cycle; mem_rdy in that cycle
    // still wins because the error branch is only taken when mem_rdy is low.
    assign tmo_hit   = (tmo_cnt == 8'(MEM_TIMEOUT - 1));
    assign mem_state = (state == S_FETCH) || (state == S_LOAD) || (state == S_STORE);
    assign state_o   = state;

    // State register, per-request wait counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            tmo_cnt <= 8'd0;
            retired <= '0;
        end else begin
            state <= state_next;
            // Any state change restarts the count, so each request begins at 0.
            if (state_next != state)
                tmo_cnt <= 8'd0;
            else if (mem_state && !mem_rdy)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    // Next-state and output decode; reset low forces every strobe to 0.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_load    = 1'b0;
        reg_we     = 1'b0;
        nz_we      = 1'b0;
        pc_enable  = 1'b0;
        bus_err    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_load    = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LD:   state_next = S_LOAD;
                    OP_ST:   state_next = S_STORE;
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                reg_we     = dec_regwrite;
                nz_we      = dec_nz;
                pc_enable  = 1'b1;
                retire     = 1'b1;
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_LOAD: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                if (mem_rdy)      state_next = S_WB;
                else if (tmo_hit) state_next = S_ERR;
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_enable  = 1'b1;
                retire     = 1'b1;
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_STORE: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = 1'b1;
                if (mem_rdy) begin
                    pc_enable  = 1'b1;
                    retire     = 1'b1;
                    state_next = run ? S_FETCH : S_IDLE;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_ERR: begin
                bus_err = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
        if (!reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_sel   = 1'b0;
            ir_load   = 1'b0;
            reg_we    = 1'b0;
            nz_we     = 1'b0;
            pc_enable = 1'b0;
            bus_err   = 1'b0;
        end
    end

endmodule
